dct_bfy_level2: RTL and testbench

Forward-side counterpart of the level-2 recombination stage in the transform datapath. Collects an 8-sample row as two 4-sample beats and, in forward mode, produces the even (sum) and odd (difference) butterfly halves; in inverse mode, it splits the row into even-index and odd-index coefficient groups. Each result is presented as two 4-lane output beats. Sits immediately upstream of the level-2 multiply/recombination stage and carries the 8/16/32 size-valid flags alongside the data with matched delay.

---
 rtl/dct_bfy_level2_pkg.sv | 35 +++
 rtl/dct_bfy_lane.sv | 45 ++++
 rtl/dct_bfy_level2.sv | 173 +++++++++++++++++
 tb/tb_dct_bfy_level2.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_bfy_level2_pkg.sv
// Shared definitions for the level-2 butterfly stage of the transform datapath.
//   - IW_DEF / OW_DEF : default sample and result widths (OW = IW + 1).
//   - size_flags_t    : {vld_32, vld_16, vld_8}, one-hot or all-zero.
//   - phase_t         : which half of the 8-sample row the next beat carries.
//   - seq_t           : which result beat currently sits on the output register.
//   - beat_strobe()   : ORs the size flags into a single "beat present" strobe.
package dct_bfy_level2_pkg;

  localparam int IW_DEF = 18;
  localparam int OW_DEF = 19;

  // Size flags are carried as a 3-bit vector, MSB = 32-point, LSB = 8-point.
  typedef logic [2:0] size_flags_t;

  localparam size_flags_t SIZE_NONE = 3'b000;
  localparam size_flags_t SIZE_8    = 3'b001;
  localparam size_flags_t SIZE_16   = 3'b010;
  localparam size_flags_t SIZE_32   = 3'b100;

  typedef enum logic {
    PH_A = 1'b0,   // expecting x0..x3
    PH_B = 1'b1    // expecting x4..x7
  } phase_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,  // nothing valid on the outputs
    SEQ_EVEN = 2'd1,  // E half is on the outputs, O half still owed
    SEQ_ODD  = 2'd2   // O half is on the outputs, row complete
  } seq_t;

  function automatic logic beat_strobe(input size_flags_t flags);
    return |flags;
  endfunction

endpackage

// File: rtl/dct_bfy_lane.sv
// One lane of the level-2 butterfly.
//   Forward : e = a + b, o = a - b   (operands sign-extended to OW first)
//   Inverse : e = inv_e, o = inv_o   (sign-extended pass-through)
// Ports:
//   inverse            in   1   mode select (0 = butterfly, 1 = even/odd split)
//   fwd_a, fwd_b       in   IW  butterfly operands x[i], x[7-i]
//   inv_e, inv_o       in   IW  split operands x[2i], x[2i+1]
//   e, o               out  OW  even/sum and odd/difference results
// Purely combinational; the top module registers the results.
module dct_bfy_lane
  import dct_bfy_level2_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                 inverse,
  input  logic signed [IW-1:0] fwd_a,
  input  logic signed [IW-1:0] fwd_b,
  input  logic signed [IW-1:0] inv_e,
  input  logic signed [IW-1:0] inv_o,
  output logic signed [OW-1:0] e,
  output logic signed [OW-1:0] o
);

  logic signed [OW-1:0] a_ext;
  logic signed [OW-1:0] b_ext;
  logic signed [OW-1:0] ie_ext;
  logic signed [OW-1:0] io_ext;

  // Widen before the add/sub so the full-range sum/difference cannot wrap.
  assign a_ext  = OW'(fwd_a);
  assign b_ext  = OW'(fwd_b);
  assign ie_ext = OW'(inv_e);
  assign io_ext = OW'(inv_o);

  always_comb begin
    e = a_ext + b_ext;
    o = a_ext - b_ext;
    if (inverse) begin
      e = ie_ext;
      o = io_ext;
    end
  end

endmodule

// File: rtl/dct_bfy_level2.sv
// Level-2 butterfly stage (forward side).
// Collects an 8-sample row as two 4-lane beats (A = x0..x3, B = x4..x7) and
// emits two 4-lane result beats: first the even/sum half, then the
// odd/difference half. In inverse mode the row is split into even-index and
// odd-index samples instead. The size flag seen with beat B travels with both
// result beats.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_dt_vld_32/16/8                input beat valid, one per transform size
//   i_inverse                       0 = butterfly, 1 = even/odd split (taken at beat B)
//   i_data0..i_data3                IW-bit signed input lanes
//   o_dt_vld_32/16/8                output beat valid, size of the row
//   o_odd                           0 = E beat, 1 = O beat
//   o_data0..o_data3                OW-bit signed output lanes
// Latency: E one cycle after beat B, O two cycles after beat B.
module dct_bfy_level2
  import dct_bfy_level2_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_dt_vld_32,
  input  logic                 i_dt_vld_16,
  input  logic                 i_dt_vld_8,
  input  logic                 i_inverse,
  input  logic signed [IW-1:0] i_data0,
  input  logic signed [IW-1:0] i_data1,
  input  logic signed [IW-1:0] i_data2,
  input  logic signed [IW-1:0] i_data3,
  output logic                 o_dt_vld_32,
  output logic                 o_dt_vld_16,
  output logic                 o_dt_vld_8,
  output logic                 o_odd,
  output logic signed [OW-1:0] o_data0,
  output logic signed [OW-1:0] o_data1,
  output logic signed [OW-1:0] o_data2,
  output logic signed [OW-1:0] o_data3
);

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  size_flags_t          in_flags;
  logic                 beat;
  logic                 beat_a;
  logic                 beat_b;

  logic signed [IW-1:0] din   [4];
  logic signed [IW-1:0] a_buf [4];
  logic signed [IW-1:0] x     [8];

  phase_t               phase;
  phase_t               phase_next;

  assign in_flags = {i_dt_vld_32, i_dt_vld_16, i_dt_vld_8};
  assign beat     = beat_strobe(in_flags);
  assign beat_a   = beat && (phase == PH_A);
  assign beat_b   = beat && (phase == PH_B);

  assign din[0] = i_data0;
  assign din[1] = i_data1;
  assign din[2] = i_data2;
  assign din[3] = i_data3;

  // Full row view during beat B: stored first half plus the live second half.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign x[gi]     = a_buf[gi];
    assign x[gi + 4] = din[gi];
  end

  // ---------------------------------------------------------------------------
  // Butterfly lanes
  // ---------------------------------------------------------------------------
  logic signed [OW-1:0] e_calc [4];
  logic signed [OW-1:0] o_calc [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    dct_bfy_lane #(
      .IW (IW),
      .OW (OW)
    ) u_lane (
      .inverse (i_inverse),
      .fwd_a   (x[gi]),
      .fwd_b   (x[7 - gi]),
      .inv_e   (x[2 * gi]),
      .inv_o   (x[2 * gi + 1]),
      .e       (e_calc[gi]),
      .o       (o_calc[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Output sequencer
  // ---------------------------------------------------------------------------
  // The E half goes straight into the output register at beat B, so only the
  // O half needs its own holding register until the following cycle.
  seq_t                 seq;
  seq_t                 seq_next;
  size_flags_t          size_reg;
  size_flags_t          vld_reg;
  size_flags_t          vld_next;
  logic                 odd_reg;
  logic                 odd_next;
  logic signed [OW-1:0] o_buf     [4];
  logic signed [OW-1:0] dout_reg  [4];
  logic signed [OW-1:0] dout_next [4];

  always_comb begin
    phase_next = phase;
    if (beat) begin
      phase_next = (phase == PH_A) ? PH_B : PH_A;
    end
  end

  // Beat B can never coincide with SEQ_EVEN (a beat A must come in between),
  // so the priority order below only matters for readability.
  always_comb begin
    seq_next  = SEQ_IDLE;
    vld_next  = SIZE_NONE;
    odd_next  = 1'b0;
    dout_next = dout_reg;
    if (beat_b) begin
      seq_next  = SEQ_EVEN;
      vld_next  = in_flags;
      dout_next = e_calc;
    end else if (seq == SEQ_EVEN) begin
      seq_next  = SEQ_ODD;
      vld_next  = size_reg;
      odd_next  = 1'b1;
      dout_next = o_buf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_A;
      seq      <= SEQ_IDLE;
      size_reg <= SIZE_NONE;
      vld_reg  <= SIZE_NONE;
      odd_reg  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        a_buf[k]    <= '0;
        o_buf[k]    <= '0;
        dout_reg[k] <= '0;
      end
    end else begin
      phase    <= phase_next;
      seq      <= seq_next;
      vld_reg  <= vld_next;
      odd_reg  <= odd_next;
      dout_reg <= dout_next;
      if (beat_a) begin
        a_buf <= din;
      end
      if (beat_b) begin
        o_buf    <= o_calc;
        size_reg <= in_flags;
      end
    end
  end

  assign o_dt_vld_32 = vld_reg[2];
  assign o_dt_vld_16 = vld_reg[1];
  assign o_dt_vld_8  = vld_reg[0];
  assign o_odd       = odd_reg;
  assign o_data0     = dout_reg[0];
  assign o_data1     = dout_reg[1];
  assign o_data2     = dout_reg[2];
  assign o_data3     = dout_reg[3];

endmodule

// File: tb/tb_dct_bfy_level2.sv
// Directed bench for dct_bfy_level2: reset, forward/inverse rows, extremes,
// gapped beats, streaming rows and reset in the middle of a row.
module tb_dct_bfy_level2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_dt_vld_32 = 1'b0;
  logic                i_dt_vld_16 = 1'b0;
  logic                i_dt_vld_8 = 1'b0;
  logic                i_inverse = 1'b0;
  logic signed [17:0]  i_data0 = '0;
  logic signed [17:0]  i_data1 = '0;
  logic signed [17:0]  i_data2 = '0;
  logic signed [17:0]  i_data3 = '0;
  logic                o_dt_vld_32;
  logic                o_dt_vld_16;
  logic                o_dt_vld_8;
  logic                o_odd;
  logic signed [18:0]  o_data0;
  logic signed [18:0]  o_data1;
  logic signed [18:0]  o_data2;
  logic signed [18:0]  o_data3;

  int total = 0;
  int bad   = 0;
  int rows [4][8];

  dct_bfy_level2 #(.IW(18), .OW(19)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_dt_vld_32 (i_dt_vld_32),
    .i_dt_vld_16 (i_dt_vld_16),
    .i_dt_vld_8  (i_dt_vld_8),
    .i_inverse   (i_inverse),
    .i_data0     (i_data0),
    .i_data1     (i_data1),
    .i_data2     (i_data2),
    .i_data3     (i_data3),
    .o_dt_vld_32 (o_dt_vld_32),
    .o_dt_vld_16 (o_dt_vld_16),
    .o_dt_vld_8  (o_dt_vld_8),
    .o_odd       (o_odd),
    .o_data0     (o_data0),
    .o_data1     (o_data1),
    .o_data2     (o_data2),
    .o_data3     (o_data3)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {vld32, vld16, vld8, odd, d0, d1, d2, d3}.
  function automatic logic [79:0] obs();
    return {o_dt_vld_32, o_dt_vld_16, o_dt_vld_8, o_odd,
            o_data0, o_data1, o_data2, o_data3};
  endfunction

  function automatic logic [79:0] expv(input logic [2:0] f, input logic odd,
                                       input int v0, input int v1,
                                       input int v2, input int v3);
    return {f, odd, v0[18:0], v1[18:0], v2[18:0], v3[18:0]};
  endfunction

  function automatic logic [3:0] obs_ctl();
    return {o_dt_vld_32, o_dt_vld_16, o_dt_vld_8, o_odd};
  endfunction

  // Reference for the streaming rows: butterfly or even/odd split of one row.
  function automatic int model(input int r, input logic inv, input logic odd, input int lane);
    if (inv) return rows[r][2 * lane + (odd ? 1 : 0)];
    if (odd) return rows[r][lane] - rows[r][7 - lane];
    return rows[r][lane] + rows[r][7 - lane];
  endfunction

  task automatic drive(input logic [2:0] f, input logic inv,
                       input int d0, input int d1, input int d2, input int d3);
    {i_dt_vld_32, i_dt_vld_16, i_dt_vld_8} = f;
    i_inverse = inv;
    i_data0 = d0[17:0];
    i_data1 = d1[17:0];
    i_data2 = d2[17:0];
    i_data3 = d3[17:0];
  endtask

  task automatic idle();
    {i_dt_vld_32, i_dt_vld_16, i_dt_vld_8} = 3'b000;
    i_inverse = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [79:0] e;
    e = '0;
    #1;
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_initial got=%h exp=%h", obs(), e);
    end
    // A beat presented during reset must not produce anything.
    drive(3'b001, 1'b0, 1, 2, 3, 4);
    step();
    drive(3'b001, 1'b0, 5, 6, 7, 8);
    step();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), e);
    end
    idle();
    rst_n = 1'b1;
    step();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_forward();
    logic [79:0] e;
    drive(3'b001, 1'b0, 1, 2, 3, 4);
    step();
    drive(3'b001, 1'b0, 5, 6, 7, 8);
    step();
    e = expv(3'b001, 1'b0, 9, 9, 9, 9);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL fwd_E got=%h exp=%h", obs(), e);
    end
    idle();
    step();
    e = expv(3'b001, 1'b1, -7, -5, -3, -1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL fwd_O got=%h exp=%h", obs(), e);
    end
    step();
    total++;
    if (obs_ctl() !== 4'b0000) begin
      bad++;
      $display("FAIL fwd_idle got=%b exp=%b", obs_ctl(), 4'b0000);
    end
  endtask

  task automatic test_inverse();
    logic [79:0] e;
    drive(3'b100, 1'b0, 1, 2, 3, 4);
    step();
    drive(3'b100, 1'b1, 5, 6, 7, 8);
    step();
    e = expv(3'b100, 1'b0, 1, 3, 5, 7);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL inv_E got=%h exp=%h", obs(), e);
    end
    idle();
    step();
    e = expv(3'b100, 1'b1, 2, 4, 6, 8);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL inv_O got=%h exp=%h", obs(), e);
    end
    step();
  endtask

  task automatic test_extremes();
    logic [79:0] e;
    // x0 = x7 = min, everything else max.
    drive(3'b010, 1'b0, -131072, 131071, 131071, 131071);
    step();
    drive(3'b010, 1'b0, 131071, 131071, 131071, -131072);
    step();
    e = expv(3'b010, 1'b0, -262144, 262142, 262142, 262142);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL ext_min_E got=%h exp=%h", obs(), e);
    end
    idle();
    step();
    e = expv(3'b010, 1'b1, 0, 0, 0, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL ext_min_O got=%h exp=%h", obs(), e);
    end
    // Largest differences: max - min and min - max.
    drive(3'b010, 1'b0, 131071, 0, 0, -131072);
    step();
    drive(3'b010, 1'b0, 131071, 0, 0, -131072);
    step();
    e = expv(3'b010, 1'b0, -1, 0, 0, -1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL ext_diff_E got=%h exp=%h", obs(), e);
    end
    idle();
    step();
    e = expv(3'b010, 1'b1, 262143, 0, 0, -262143);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL ext_diff_O got=%h exp=%h", obs(), e);
    end
    step();
  endtask

  task automatic test_gap();
    logic [79:0] e;
    drive(3'b001, 1'b0, 1, 2, 3, 4);
    step();
    idle();
    for (int g = 0; g < 3; g++) begin
      step();
      total++;
      if (obs_ctl() !== 4'b0000) begin
        bad++;
        $display("FAIL gap_idle%0d got=%b exp=%b", g, obs_ctl(), 4'b0000);
      end
    end
    drive(3'b001, 1'b0, 5, 6, 7, 8);
    step();
    e = expv(3'b001, 1'b0, 9, 9, 9, 9);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL gap_E got=%h exp=%h", obs(), e);
    end
    idle();
    step();
    e = expv(3'b001, 1'b1, -7, -5, -3, -1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL gap_O got=%h exp=%h", obs(), e);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [79:0] e;
    logic [2:0]  fl [4];
    logic        inv [4];
    rows[0] = '{10, -20, 30, -40, 50, -60, 70, -80};
    rows[1] = '{1000, 2000, 3000, 4000, 5000, 6000, 7000, 8000};
    rows[2] = '{-5, -6, -7, -8, 9, 10, 11, 12};
    rows[3] = '{100, -100, 200, -200, 300, -300, 400, -400};
    fl  = '{3'b001, 3'b010, 3'b100, 3'b001};
    inv = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int r = 0; r < 4; r++) begin
      drive(fl[r], 1'b0, rows[r][0], rows[r][1], rows[r][2], rows[r][3]);
      step();
      if (r > 0) begin
        e = expv(fl[r-1], 1'b1, model(r-1, inv[r-1], 1'b1, 0), model(r-1, inv[r-1], 1'b1, 1),
                 model(r-1, inv[r-1], 1'b1, 2), model(r-1, inv[r-1], 1'b1, 3));
        total++;
        if (obs() !== e) begin
          bad++;
          $display("FAIL stream_O%0d got=%h exp=%h", r - 1, obs(), e);
        end
      end
      drive(fl[r], inv[r], rows[r][4], rows[r][5], rows[r][6], rows[r][7]);
      step();
      e = expv(fl[r], 1'b0, model(r, inv[r], 1'b0, 0), model(r, inv[r], 1'b0, 1),
               model(r, inv[r], 1'b0, 2), model(r, inv[r], 1'b0, 3));
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL stream_E%0d got=%h exp=%h", r, obs(), e);
      end
    end
    idle();
    step();
    e = expv(fl[3], 1'b1, model(3, inv[3], 1'b1, 0), model(3, inv[3], 1'b1, 1),
             model(3, inv[3], 1'b1, 2), model(3, inv[3], 1'b1, 3));
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL stream_O3 got=%h exp=%h", obs(), e);
    end
    step();
    total++;
    if (obs_ctl() !== 4'b0000) begin
      bad++;
      $display("FAIL stream_idle got=%b exp=%b", obs_ctl(), 4'b0000);
    end
  endtask

  task automatic test_reset_mid();
    logic [79:0] e;
    // Reset while the O beat is still owed: it must never appear.
    drive(3'b001, 1'b0, 1, 2, 3, 4);
    step();
    drive(3'b001, 1'b0, 5, 6, 7, 8);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    e = '0;
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rstmid_pendO_zero got=%h exp=%h", obs(), e);
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (obs_ctl() !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_noO got=%b exp=%b", obs_ctl(), 4'b0000);
    end
    // Reset between beat A and beat B: the partial row is discarded.
    drive(3'b010, 1'b0, 100, 100, 100, 100);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rstmid_partial_zero got=%h exp=%h", obs(), e);
    end
    step();
    rst_n = 1'b1;
    drive(3'b001, 1'b0, 1, 2, 3, 4);
    step();
    total++;
    if (obs_ctl() !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_newA got=%b exp=%b", obs_ctl(), 4'b0000);
    end
    drive(3'b001, 1'b0, 5, 6, 7, 8);
    step();
    e = expv(3'b001, 1'b0, 9, 9, 9, 9);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rstmid_E got=%h exp=%h", obs(), e);
    end
    idle();
    step();
    e = expv(3'b001, 1'b1, -7, -5, -3, -1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rstmid_O got=%h exp=%h", obs(), e);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_extremes();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
